// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
//
// Shared definitions for the PRBS generator/checker pair.
//   chk_state_e     : checker state (HUNT while acquiring, LOCKED once aligned)
//   DEFAULT_TAPS_16 : maximal-length 16-bit XNOR tap mask (taps 16,15,13,4)
//   MAX_WIDTH       : widest LFSR the feedback helper accepts
//   lfsr_fb()       : XNOR feedback bit of a state under a tap mask
//   lfsr_next()     : one Fibonacci shift step (newest bit enters at bit 0)
// ---------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    localparam logic [15:0] DEFAULT_TAPS_16 = 16'hD008;

    localparam int MAX_WIDTH = 32;

    // Narrower states and masks are zero-extended by the caller; the extra
    // zero bits do not change the XNOR reduction because the mask is zero
    // there as well.
    function automatic logic lfsr_fb(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps
    );
        return ~^(state & taps);
    endfunction

    // Shift left by one and append the feedback bit. The caller masks the
    // result back down to its own width.
    function automatic logic [MAX_WIDTH-1:0] lfsr_next(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps
    );
        return {state[MAX_WIDTH-2:0], lfsr_fb(state, taps)};
    endfunction

endpackage

// File: rtl/lfsr_prbs_checker.sv
// ---------------------------------------------------------------------------
// lfsr_prbs_checker
//
// Self-synchronising PRBS checker. In HUNT it fills a WIDTH-bit shift
// register from the received stream and then predicts each following bit
// from the LFSR feedback rule; LOCK_CNT consecutive correct predictions move
// it to LOCKED. In LOCKED the shift register free-runs on its own
// predictions, so a corrupted received bit is counted once and never
// poisons later predictions. UNLOCK_CNT consecutive mismatches drop back to
// HUNT and restart the fill.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   reset_n    in   asynchronous active-low reset
//   rx_bit     in   received serial bit
//   rx_valid   in   rx_bit qualifier
//   clr_cnt    in   synchronous clear of err_cnt
//   state_o    out  registered checker state (HUNT/LOCKED)
//   err_pulse  out  one-cycle pulse per counted mismatch
//   err_cnt    out  saturating mismatch count
//
// Handshake: there is no back-pressure. A cycle with rx_valid high delivers
// exactly one bit and is the only kind of cycle that advances the shift
// register, the fill/match/miss counters or the state; with rx_valid low all
// of those hold. clr_cnt acts on any cycle regardless of rx_valid.
// ---------------------------------------------------------------------------
module lfsr_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS_16),
    parameter int               LOCK_CNT   = 32,
    parameter int               UNLOCK_CNT = 8,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             clr_cnt,
    output chk_state_e       state_o,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

    chk_state_e         state_q;
    logic [WIDTH-1:0]   s_q;
    logic [FILL_W-1:0]  fill_q;
    logic [MATCH_W-1:0] match_q;
    logic [MISS_W-1:0]  miss_q;
    logic               err_pulse_q;
    logic [CNT_W-1:0]   err_cnt_q;

    logic               pred;
    logic               mismatch;
    logic               filled;
    logic               count_err;
    logic [CNT_W-1:0]   err_cnt_inc;

    // Prediction of the next bit from the last WIDTH bits held in s_q.
    always_comb begin
        pred        = lfsr_fb(MAX_WIDTH'(s_q), MAX_WIDTH'(TAPS));
        mismatch    = (rx_bit != pred);
        filled      = (fill_q == FILL_W'(WIDTH));
        count_err   = rx_valid && (state_q == LOCKED) && mismatch;
        err_cnt_inc = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= count_err;

            // A clear that lands on a counted mismatch keeps that mismatch.
            if (clr_cnt) begin
                err_cnt_q <= count_err ? CNT_W'(1) : '0;
            end else if (count_err) begin
                err_cnt_q <= err_cnt_inc;
            end

            if (rx_valid) begin
                case (state_q)
                    HUNT: begin
                        // Always shift the received bit in: once filled this
                        // is what makes the checker self-synchronising.
                        s_q <= {s_q[WIDTH-2:0], rx_bit};
                        if (!filled) begin
                            fill_q <= fill_q + 1'b1;
                        end else if (mismatch) begin
                            match_q <= '0;
                        end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_q <= LOCKED;
                            match_q <= '0;
                            miss_q  <= '0;
                        end else begin
                            match_q <= match_q + 1'b1;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction, not the received bit.
                        s_q <= {s_q[WIDTH-2:0], pred};
                        if (!mismatch) begin
                            miss_q <= '0;
                        end else if (miss_q == MISS_W'(UNLOCK_CNT - 1)) begin
                            state_q <= HUNT;
                            fill_q  <= '0;
                            match_q <= '0;
                            miss_q  <= '0;
                        end else begin
                            miss_q <= miss_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    assign state_o   = state_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: rtl/lfsr_prbs_gen_chk.sv
// ---------------------------------------------------------------------------
// lfsr_prbs_gen_chk
//
// PRBS generator and checker pair for link/datapath BIST. The generator is
// an XNOR Fibonacci LFSR with enable, seed load and lock-up protection; its
// serial output is intended to be looped through the path under test back
// into the checker.
//
// Ports
//   clk       in   clock, all state on the rising edge
//   reset_n   in   asynchronous active-low reset
//   gen_en    in   advance the generator one step this cycle
//   load      in   load seed_in into the generator (wins over gen_en)
//   seed_in   in   seed for load; all-ones is replaced by all-zeros
//   q         out  generator state
//   prbs_bit  out  serial output, q[0] (newest bit)
//   rx_bit    in   received serial bit
//   rx_valid  in   rx_bit qualifier
//   clr_cnt   in   synchronous clear of err_cnt
//   locked    out  checker locked
//   err_pulse out  one-cycle pulse per counted mismatch
//   err_cnt   out  saturating mismatch count
// ---------------------------------------------------------------------------
module lfsr_prbs_gen_chk
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS_16),
    parameter logic [WIDTH-1:0] SEED       = '0,
    parameter int               LOCK_CNT   = 32,
    parameter int               UNLOCK_CNT = 8,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             gen_en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             prbs_bit,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    // All-ones is the XNOR lock-up state; never reset into it even if SEED
    // is mis-set.
    localparam logic [WIDTH-1:0] RESET_Q = (&SEED) ? '0 : SEED;

    // -----------------------------------------------------------------------
    // Generator
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] gen_q;
    logic [WIDTH-1:0] gen_d;
    logic [WIDTH-1:0] gen_step;

    always_comb begin
        gen_step = WIDTH'(lfsr_next(MAX_WIDTH'(gen_q), MAX_WIDTH'(TAPS)));
        gen_d    = gen_q;
        if (load) begin
            gen_d = (&seed_in) ? '0 : seed_in;
        end else if (gen_en) begin
            // Escape from lock-up: all-ones would otherwise map to itself.
            gen_d = (&gen_q) ? '0 : gen_step;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_q <= RESET_Q;
        end else begin
            gen_q <= gen_d;
        end
    end

    assign q        = gen_q;
    assign prbs_bit = gen_q[0];

    // -----------------------------------------------------------------------
    // Checker
    // -----------------------------------------------------------------------
    chk_state_e chk_state;

    lfsr_prbs_checker #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .CNT_W      (CNT_W)
    ) u_checker (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .clr_cnt   (clr_cnt),
        .state_o   (chk_state),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    // The state register is the lock flag, so locked is registered as well.
    assign locked = (chk_state == LOCKED);

endmodule

// File: tb/tb_lfsr_prbs_gen_chk.sv
// ---------------------------------------------------------------------------
// tb_lfsr_prbs_gen_chk
//
// Drives the generator/checker pair with directed and randomised cycles.
// Every driven cycle advances a behavioural model (integer arithmetic and a
// parity count) and pushes the expected post-edge outputs into exp_q; an
// independent monitor pops one entry per clock edge and compares. Directed
// checks against constants cover the documented sequences and timings.
// The error counter is built 4 bits wide so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_lfsr_prbs_gen_chk;

    localparam int               W        = 16;
    localparam int               CW       = 4;
    localparam logic [W-1:0]     TAPS     = 16'hD008;
    localparam int               LOCK_N   = 32;
    localparam int               UNLOCK_N = 8;
    localparam int               SB_W     = W + 3 + CW;
    localparam int unsigned      MASK     = (1 << W) - 1;
    localparam int unsigned      CNT_MAX  = (1 << CW) - 1;

    // -----------------------------------------------------------------------
    // Clock / reset and DUT
    // -----------------------------------------------------------------------
    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          gen_en   = 1'b0;
    logic          load     = 1'b0;
    logic [W-1:0]  seed_in  = '0;
    logic          rx_bit   = 1'b0;
    logic          rx_valid = 1'b0;
    logic          clr_cnt  = 1'b0;
    logic [W-1:0]  q;
    logic          prbs_bit;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    lfsr_prbs_gen_chk #(
        .WIDTH      (W),
        .TAPS       (TAPS),
        .SEED       (16'h0000),
        .LOCK_CNT   (LOCK_N),
        .UNLOCK_CNT (UNLOCK_N),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .gen_en    (gen_en),
        .load      (load),
        .seed_in   (seed_in),
        .q         (q),
        .prbs_bit  (prbs_bit),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    int               errors = 0;
    int               checks = 0;
    logic [SB_W-1:0]  exp_q[$];
    logic [SB_W-1:0]  mon_exp;
    logic [SB_W-1:0]  mon_act;
    bit               seen_ffff = 0;

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    int unsigned m_q;       // generator value
    int unsigned m_hist;    // last W bits seen (received in HUNT, predicted in LOCKED)
    bit          m_locked;
    bit          m_pulse;
    int unsigned m_cnt;
    int          m_fill;
    int          m_match;
    int          m_miss;

    // Next sequence bit: 1 when an even number of tapped bits are set.
    function automatic bit next_bit(input int unsigned v);
        return ($countones(v & TAPS) % 2) == 0;
    endfunction

    function automatic void model_reset();
        m_q      = 0;
        m_hist   = 0;
        m_locked = 0;
        m_pulse  = 0;
        m_cnt    = 0;
        m_fill   = 0;
        m_match  = 0;
        m_miss   = 0;
    endfunction

    function automatic void model_cycle(input bit ge, input bit ld, input int unsigned seed,
                                        input bit rv, input bit rb, input bit clr);
        bit p;
        if (ld) m_q = (seed == MASK) ? 0 : seed;
        else if (ge) m_q = (m_q == MASK) ? 0 : (((m_q << 1) | int'(next_bit(m_q))) & MASK);

        m_pulse = 0;
        if (rv) begin
            if (!m_locked) begin
                if (m_fill < W) m_fill++;
                else if (rb == next_bit(m_hist)) m_match++;
                else m_match = 0;
                m_hist = ((m_hist << 1) | int'(rb)) & MASK;
                if (m_match == LOCK_N) begin
                    m_locked = 1;
                    m_match  = 0;
                    m_miss   = 0;
                end
            end else begin
                p = next_bit(m_hist);
                m_hist = ((m_hist << 1) | int'(p)) & MASK;
                if (rb != p) begin
                    m_pulse = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_miss++;
                    if (m_miss == UNLOCK_N) begin
                        m_locked = 0;
                        m_fill   = 0;
                        m_match  = 0;
                        m_miss   = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (clr) m_cnt = m_pulse ? 1 : 0;
    endfunction

    // -----------------------------------------------------------------------
    // Driver: one clock cycle of stimulus. rx_bit is the model's current
    // serial bit, optionally inverted, which emulates the loopback path.
    // Returns 2 time units after the rising edge.
    // -----------------------------------------------------------------------
    task automatic step(input bit ge, input bit ld, input logic [W-1:0] seed,
                        input bit rv, input bit inv, input bit clr);
        @(negedge clk);
        gen_en   = ge;
        load     = ld;
        seed_in  = seed;
        rx_valid = rv;
        clr_cnt  = clr;
        rx_bit   = m_q[0] ^ inv;
        model_cycle(ge, ld, int'(seed), rv, rx_bit, clr);
        exp_q.push_back({m_q[W-1:0], m_q[0], m_locked, m_pulse, m_cnt[CW-1:0]});
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor: one comparison per edge that has an expected entry
    // -----------------------------------------------------------------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q === 16'hFFFF) seen_ffff = 1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {q, prbs_bit, locked, err_pulse, err_cnt};
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL scoreboard t=%0t got q/prbs/lock/pulse/cnt=%h expected %h",
                                 $time, mon_act, mon_exp);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    logic [W-1:0] seq_exp [5] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001E};
    int           first_zero;
    int           first_lock;
    int           pulses;
    int           n;
    logic [W-1:0] q_hold;
    bit           r_ge, r_ld, r_rv, r_inv, r_clr;
    logic [W-1:0] r_seed;

    initial begin
        model_reset();
        #12;
        check("reset_q", 32'(q), 32'h0);
        check("reset_locked", 32'(locked), 32'h0);
        check("reset_err_cnt", 32'(err_cnt), 32'h0);
        check("reset_err_pulse", 32'(err_pulse), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full period in loopback: sequence start, lock time, return to zero.
        first_zero = 0;
        first_lock = 0;
        for (int k = 1; k <= 65535; k++) begin
            step(1, 0, '0, 1, 0, 0);
            if (k <= 5) check($sformatf("seq_q_%0d", k), 32'(q), 32'(seq_exp[k-1]));
            if (q == 16'h0000 && first_zero == 0) first_zero = k;
            if (locked === 1'b1 && first_lock == 0) first_lock = k;
        end
        check("period_steps", 32'(first_zero), 32'd65535);
        check("lock_after_bits", 32'(first_lock), 32'd48);
        check("loopback_err_cnt", 32'(err_cnt), 32'h0);
        check("ffff_seen", 32'(seen_ffff), 32'h0);

        // Single inverted bit while locked.
        pulses = 0;
        step(1, 0, '0, 1, 1, 0);
        pulses += int'(err_pulse);
        check("single_err_cnt", 32'(err_cnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, '0, 1, 0, 0);
            pulses += int'(err_pulse);
        end
        check("single_err_pulses", 32'(pulses), 32'h1);
        check("single_err_locked", 32'(locked), 32'h1);
        step(1, 0, '0, 1, 0, 1);
        check("clr_cnt", 32'(err_cnt), 32'h0);

        // Continuous inversion: 8 mismatches drop lock, then relock.
        for (int i = 1; i <= UNLOCK_N; i++) begin
            step(1, 0, '0, 1, 1, 0);
            if (i == UNLOCK_N - 1) check("locked_before_unlock", 32'(locked), 32'h1);
        end
        check("unlock_locked", 32'(locked), 32'h0);
        check("unlock_err_cnt", 32'(err_cnt), 32'h8);
        n = 0;
        while (locked !== 1'b1 && n < 200) begin
            step(1, 0, '0, 1, 0, 0);
            n++;
        end
        check("relock_bits", 32'(n), 32'd48);

        // Second burst pushes the 4-bit counter past its maximum.
        for (int i = 1; i <= UNLOCK_N; i++) step(1, 0, '0, 1, 1, 0);
        check("sat_err_cnt", 32'(err_cnt), 32'(CNT_MAX));
        check("sat_locked", 32'(locked), 32'h0);
        n = 0;
        while (locked !== 1'b1 && n < 200) begin
            step(1, 0, '0, 1, 0, 0);
            n++;
        end
        check("relock2_bits", 32'(n), 32'd48);

        // Pause both generator and receiver: nothing moves.
        q_hold = q;
        for (int i = 0; i < 100; i++) step(0, 0, '0, 0, 0, 0);
        check("pause_q", 32'(q), 32'(q_hold));
        check("pause_locked", 32'(locked), 32'h1);
        check("pause_err_cnt", 32'(err_cnt), 32'(CNT_MAX));
        for (int i = 0; i < 20; i++) step(1, 0, '0, 1, 0, 0);
        check("resume_locked", 32'(locked), 32'h1);

        // Asynchronous reset between clock edges.
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_q", 32'(q), 32'h0);
        check("async_rst_locked", 32'(locked), 32'h0);
        check("async_rst_err_cnt", 32'(err_cnt), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Seed load: all-ones is sanitised, load beats gen_en.
        step(0, 1, 16'hFFFF, 0, 0, 0);
        check("load_ffff", 32'(q), 32'h0);
        step(1, 1, 16'h1234, 0, 0, 0);
        check("load_over_gen_en", 32'(q), 32'h1234);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r_ge   = ($urandom_range(0, 99) < 90);
            r_rv   = r_ge ? 1'b1 : ($urandom_range(0, 19) == 0);
            r_ld   = ($urandom_range(0, 299) == 0);
            r_seed = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            r_inv  = ($urandom_range(0, 39) == 0);
            r_clr  = ($urandom_range(0, 99) == 0);
            step(r_ge, r_ld, r_seed, r_rv, r_inv, r_clr);
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_gen_chk.md
Name: lfsr_prbs_gen_chk

Overview:
- Parametrised PRBS generator and checker pair built on an XNOR Fibonacci LFSR.
- Generalises the fixed 16-bit free-running LFSR with: width/tap parameters, enable, seed load, lock-up protection, and a self-synchronising checker with lock detection and error counting.
- Used for link and datapath BIST: generator output is looped through the path under test into the checker.

Parameters:
- WIDTH, 16, LFSR length in bits (4..32).
- TAPS, 16'hD008, feedback mask; bit i set means Q[i] is in the XNOR (default is taps 16,15,13,4, maximal length).
- SEED, 0, generator reset value; must not be all-ones.
- LOCK_CNT, 32, consecutive correct predictions required to declare lock.
- UNLOCK_CNT, 8, consecutive mismatches while locked that drop lock.
- CNT_W, 16, error counter width.

Ports:
- clk, in, 1, single clock; all state on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- gen_en, in, 1, advance generator one step this cycle.
- load, in, 1, load seed_in into generator (priority over gen_en).
- seed_in, in, WIDTH, seed value for load.
- q, out, WIDTH, generator state.
- prbs_bit, out, 1, serial output, equal to q[0] (newest bit).
- rx_bit, in, 1, received serial bit.
- rx_valid, in, 1, rx_bit is valid this cycle.
- clr_cnt, in, 1, synchronous clear of err_cnt.
- locked, out, 1, checker locked.
- err_pulse, out, 1, one-cycle pulse per counted mismatch.
- err_cnt, out, CNT_W, saturating mismatch count.

Behaviour:
- Feedback: fb(x) = ~^(x & TAPS). Step: x_next = {x[WIDTH-2:0], fb(x)}. The all-ones state is the XNOR lock-up state.
- Reset (reset_n low, async): q = SEED, locked = 0, err_pulse = 0, err_cnt = 0, checker in HUNT with fill count 0 and match count 0.
- Generator, one action per cycle in priority order:
  - load: q <= seed_in; an all-ones seed_in is replaced by all-zeros.
  - else gen_en: q <= step(q).
  - else hold.
  - If q is all-ones (unreachable except by fault), the next enabled step forces q to all-zeros.
- Generator latency: q updates the cycle after gen_en. Period is 2^WIDTH-1 for maximal taps (65535 by default).
- Checker: shift register s (WIDTH bits) and state machine HUNT/LOCKED. Only cycles with rx_valid high act; all other cycles hold all checker state.
- HUNT:
  - While fill < WIDTH: s <= {s, rx_bit}, fill++.
  - Once fill == WIDTH: pred = fb(s); s <= {s, rx_bit} (self-sync).
  - rx_bit == pred: match++. Otherwise match = 0.
  - match reaching LOCK_CNT: go to LOCKED, locked = 1 the following cycle, miss = 0.
  - No errors are counted in HUNT.
- LOCKED:
  - pred = fb(s); s <= {s, pred} (free-run, so errors do not propagate).
  - rx_bit != pred: err_cnt++ (saturates at all-ones), err_pulse = 1 next cycle, miss++.
  - rx_bit == pred: miss = 0.
  - miss reaching UNLOCK_CNT: go to HUNT, locked = 0 next cycle, fill = 0, match = 0. The mismatch that triggers unlock is still counted.
- clr_cnt zeroes err_cnt next cycle. If clr_cnt coincides with a mismatch, the result is err_cnt = 1.
- Lock time from a clean stream is WIDTH + LOCK_CNT valid bits (48 by default); locked rises on the cycle after the last of those bits.
- A reset mid-operation returns everything to reset values immediately, independent of clk.

Decomposition:
- Package lfsr_pkg holds:
  - the checker state enum {HUNT, LOCKED};
  - the DEFAULT_TAPS_16 constant 16'hD008;
  - a parametrised function lfsr_fb(state, taps) returning the XNOR feedback bit, shared by generator and checker.
- One sub-module, lfsr_prbs_checker, contains the checker state machine, counters and s.
- The generator stays in the top module.

Test Plan:
- Reset then gen_en = 1 continuously -> q = 0000, 0001, 0003, 0007, 000F, 001E; returns to 0000 after exactly 65535 steps; FFFF is never seen.
- load = 1 with seed_in = FFFF -> q = 0000 next cycle. load and gen_en both high with seed_in = 1234 -> q = 1234 (load wins).
- Loopback prbs_bit -> rx_bit, rx_valid = gen_en = 1 -> locked rises the cycle after the 48th valid bit; err_cnt stays 0 for 10000 cycles.
- While locked, invert one rx_bit -> err_cnt = 1, one err_pulse, locked stays 1. Assert clr_cnt -> err_cnt = 0.
- While locked, invert rx continuously -> err_cnt = 8, locked falls after the 8th mismatch. Remove inversion -> relock after 48 more valid bits. rx_valid low for 100 cycles mid-lock with the generator also paused -> no change.
- reset_n low asynchronously mid-lock (between clock edges) -> locked = 0, err_cnt = 0, q = 0000 immediately.
